// File: rtl/ccdl_pkg.sv
// ccdl_pkg: FSM state encoding and buffer entry width for the FFT frame feeder
package ccdl_pkg;
    typedef enum logic [2:0] {IDLE = 3'b001, RUN = 3'b010, PAD = 3'b100} state_t;
    localparam int ENTRY_BASE_W = 17;
    function automatic int entry_w(input int bin_w);
        return ENTRY_BASE_W + bin_w;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; dout shows the head entry whenever !empty
// ports: clk, rst (async, active-high), wr_en/din write side, rd_en/dout read side,
//        full/empty/count occupancy. A write while full is rejected even with a read.
module sync_fifo_fwft #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_wr, do_rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= din;
    end
endmodule

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: cuts the range-bin sample stream into NFFT-sample frames for the FFT core
// ports: clk, rst (async, active-high); din/din_valid input stream (no backpressure);
//        m_tdata/m_tvalid/m_tready/m_tlast/m_tuser output stream; pulse_done one-cycle
//        drain indication; overflow and frame_err sticky error flags.
module fft_frame_feeder
    import ccdl_pkg::*;
#(
    parameter int NFFT      = 1024,
    parameter int BUF_DEPTH = 64,
    parameter int BIN_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      din,
    input  logic             din_valid,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [BIN_W-1:0] m_tuser,
    output logic             pulse_done,
    output logic             overflow,
    output logic             frame_err
);
    localparam int SW = $clog2(NFFT);
    localparam int EW = entry_w(BIN_W);
    localparam logic [SW-1:0] LAST = SW'(NFFT - 1);
    state_t state;
    logic [SW-1:0] scnt, sidx;
    logic [BIN_W-1:0] bcnt, bidx;
    logic active, wr_en, rd_en, full, empty;
    logic [EW-1:0] wr_data, rd_data;
    logic [$clog2(BUF_DEPTH):0] count;
    // a new pulse restarts both counters, so the first entry is written with index 0
    assign sidx = state == IDLE ? '0 : scnt;
    assign bidx = state == IDLE ? '0 : bcnt;
    // padding only writes when there is room; live samples always try and may be rejected
    assign wr_en = state == PAD ? !full : din_valid;
    assign wr_data = {state == PAD ? 16'h0 : din, sidx == LAST, bidx};
    assign rd_en = m_tvalid && m_tready;
    assign m_tvalid = !empty;
    assign m_tdata = {16'h0, m_tvalid ? rd_data[EW-1 -: 16] : 16'h0};
    assign m_tlast = m_tvalid && rd_data[BIN_W];
    assign m_tuser = m_tvalid ? rd_data[BIN_W-1:0] : '0;
    assign pulse_done = active && state == IDLE && count == '0;
    sync_fifo_fwft #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (wr_data),
        .rd_en (rd_en),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            active    <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_en && full) overflow <= 1'b1;
            if (pulse_done) active <= 1'b0;
            case (state)
                IDLE: if (din_valid) begin
                    scnt   <= SW'(1);
                    bcnt   <= '0;
                    active <= 1'b1;
                    state  <= RUN;
                end
                RUN: if (din_valid) begin
                    scnt <= scnt + 1'b1;
                    if (scnt == LAST) bcnt <= bcnt + 1'b1;
                end else if (scnt == '0) begin
                    state <= IDLE;
                end else begin
                    frame_err <= 1'b1;
                    state     <= PAD;
                end
                PAD: begin
                    if (din_valid) frame_err <= 1'b1;
                    if (!full) begin
                        scnt <= scnt + 1'b1;
                        if (scnt == LAST) begin
                            bcnt  <= bcnt + 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
